// File: rtl/atconv_mem_responder.sv
// ATCONV memory-side responder: image store, layer-0/1 result banks,
// ready/busy start handshake, run completion, write counters, error flags.
module atconv_mem_responder #(
  parameter int DW            = 13,
  parameter int IMG_DEPTH     = 4096,
  parameter int L1_DEPTH      = 1024,
  parameter int START_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [11:0]   ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          start,
  output logic          ready,
  input  logic          busy,
  input  logic [12:0]   iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [12:0]   caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [12:0]   caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic          csel,
  input  logic          dbg_sel,
  input  logic [11:0]   dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic          done,
  output logic [12:0]   wr_cnt0,
  output logic [10:0]   wr_cnt1,
  output logic [2:0]    err
);

  localparam int IAW = $clog2(IMG_DEPTH);
  localparam int LAW = $clog2(L1_DEPTH);
  localparam int TW  = $clog2(START_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OFFER,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [12:0]   cnt0_q, cnt0_d;
  logic [10:0]   cnt1_q, cnt1_d;
  logic [2:0]    err_q, err_d;

  logic [DW-1:0] img_q   [IMG_DEPTH];
  logic [DW-1:0] bank0_q [IMG_DEPTH];
  logic [DW-1:0] bank1_q [L1_DEPTH];

  logic is_run;
  logic wr_in;
  logic rd_in;
  logic wr_acc;
  logic img_we;
  logic b0_we;
  logic b1_we;

  assign is_run = (state_q == S_RUN);

  always_comb begin
    if (csel) begin
      wr_in = (32'(caddr_wr) < L1_DEPTH);
      rd_in = (32'(caddr_rd) < L1_DEPTH);
    end else begin
      wr_in = (32'(caddr_wr) < IMG_DEPTH);
      rd_in = (32'(caddr_rd) < IMG_DEPTH);
    end
  end

  // Memory writes are suppressed while reset is asserted.
  assign wr_acc = reset & cwr & is_run & wr_in;
  assign b0_we  = wr_acc & ~csel;
  assign b1_we  = wr_acc & csel;
  assign img_we = reset & ld_valid & (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_OFFER;
          tmo_d      = '0;
          cnt0_d     = '0;
          cnt1_d     = '0;
          err_d[2:1] = 2'b00;
        end
      end
      S_OFFER: begin
        if (busy) begin
          state_d = S_RUN;
        end else if (tmo_q == TMO_LAST) begin
          state_d  = S_IDLE;
          err_d[1] = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RUN: begin
        if (b0_we && cnt0_q != '1) begin
          cnt0_d = cnt0_q + 1'b1;
        end
        if (b1_we && cnt1_q != '1) begin
          cnt1_d = cnt1_q + 1'b1;
        end
        if (!busy) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Error sets take priority over the start-time clear.
    if ((cwr || crd) && !is_run) begin
      err_d[2] = 1'b1;
    end
    if ((cwr && !wr_in) || (crd && !rd_in)) begin
      err_d[0] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (img_we) begin
      img_q[ld_addr[IAW-1:0]] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (b0_we) begin
      bank0_q[caddr_wr[IAW-1:0]] <= cdata_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (b1_we) begin
      bank1_q[caddr_wr[LAW-1:0]] <= cdata_wr;
    end
  end

  always_comb begin
    idata = '0;
    if (32'(iaddr) < IMG_DEPTH) begin
      idata = img_q[iaddr[IAW-1:0]];
    end
  end

  always_comb begin
    cdata_rd = '0;
    if (crd && rd_in) begin
      if (csel) begin
        cdata_rd = bank1_q[caddr_rd[LAW-1:0]];
      end else begin
        cdata_rd = bank0_q[caddr_rd[IAW-1:0]];
      end
    end
  end

  always_comb begin
    if (dbg_sel) begin
      dbg_data = bank1_q[dbg_addr[LAW-1:0]];
    end else begin
      dbg_data = bank0_q[dbg_addr[IAW-1:0]];
    end
  end

  assign ready   = (state_q == S_OFFER);
  assign done    = (state_q == S_DONE);
  assign wr_cnt0 = cnt0_q;
  assign wr_cnt1 = cnt1_q;
  assign err     = err_q;

endmodule

// File: tb/tb_atconv_mem_responder.sv
// Bench for atconv_mem_responder: behavioural model, per-cycle compare,
// directed handshake/bank scenarios and randomized traffic.
module tb_atconv_mem_responder;

  logic        clk;
  logic        reset;
  logic        ld_valid;
  logic [11:0] ld_addr;
  logic [12:0] ld_data;
  logic        start;
  logic        ready;
  logic        busy;
  logic [12:0] iaddr;
  logic [12:0] idata;
  logic        cwr;
  logic [12:0] caddr_wr;
  logic [12:0] cdata_wr;
  logic        crd;
  logic [12:0] caddr_rd;
  logic [12:0] cdata_rd;
  logic        csel;
  logic        dbg_sel;
  logic [11:0] dbg_addr;
  logic [12:0] dbg_data;
  logic        done;
  logic [12:0] wr_cnt0;
  logic [10:0] wr_cnt1;
  logic [2:0]  err;

  atconv_mem_responder dut (
    .clk      (clk),
    .reset    (reset),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .start    (start),
    .ready    (ready),
    .busy     (busy),
    .iaddr    (iaddr),
    .idata    (idata),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .csel     (csel),
    .dbg_sel  (dbg_sel),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .done     (done),
    .wr_cnt0  (wr_cnt0),
    .wr_cnt1  (wr_cnt1),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: phase 0 idle, 1 offering, 2 running, 3 finishing
  int          mph = 0;
  int          mtmo = 0;
  int          mc0 = 0;
  int          mc1 = 0;
  logic [2:0]  merr = 3'b000;
  logic [12:0] img_m [0:4095];
  logic [12:0] b0_m  [0:4095];
  logic [12:0] b1_m  [0:1023];

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    if (!$isunknown(exp)) begin
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end
    end
  endtask

  function automatic bit in_rng(logic sel, logic [12:0] a);
    return sel ? (int'(a) < 1024) : (int'(a) < 4096);
  endfunction

  always @(posedge clk) begin
    int  old;
    bit  wok;
    bit  rok;
    if (!reset) begin
      mph  = 0;
      mtmo = 0;
      mc0  = 0;
      mc1  = 0;
      merr = 3'b000;
    end else begin
      old = mph;
      wok = in_rng(csel, caddr_wr);
      rok = in_rng(csel, caddr_rd);
      if (cwr && old == 2 && wok) begin
        if (csel) begin
          b1_m[caddr_wr] = cdata_wr;
          if (mc1 < 2047) mc1++;
        end else begin
          b0_m[caddr_wr] = cdata_wr;
          if (mc0 < 8191) mc0++;
        end
      end
      case (old)
        0: begin
          if (ld_valid) img_m[ld_addr] = ld_data;
          if (start) begin
            mph = 1;
            mtmo = 0;
            mc0 = 0;
            mc1 = 0;
            merr[2:1] = 2'b00;
          end
        end
        1: begin
          if (busy) mph = 2;
          else if (mtmo == 15) begin
            mph = 0;
            merr[1] = 1'b1;
          end else mtmo++;
        end
        2: if (!busy) mph = 3;
        default: mph = 0;
      endcase
      if ((cwr || crd) && old != 2) merr[2] = 1'b1;
      if ((cwr && !wok) || (crd && !rok)) merr[0] = 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [12:0] e_id;
    logic [12:0] e_cd;
    logic [12:0] e_dbg;
    if (chk_en) begin
      e_id  = (int'(iaddr) < 4096) ? img_m[iaddr[11:0]] : 13'd0;
      e_cd  = 13'd0;
      if (crd && in_rng(csel, caddr_rd))
        e_cd = csel ? b1_m[caddr_rd] : b0_m[caddr_rd];
      e_dbg = dbg_sel ? b1_m[dbg_addr[9:0]] : b0_m[dbg_addr];
      cmp("ready", 32'(ready), 32'(mph == 1));
      cmp("done", 32'(done), 32'(mph == 3));
      cmp("wr_cnt0", 32'(wr_cnt0), 32'(mc0));
      cmp("wr_cnt1", 32'(wr_cnt1), 32'(mc1));
      cmp("err", 32'(err), 32'(merr));
      cmp("idata", 32'(idata), 32'(e_id));
      cmp("cdata_rd", 32'(cdata_rd), 32'(e_cd));
      cmp("dbg_data", 32'(dbg_data), 32'(e_dbg));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_valid = 0; ld_addr = 0; ld_data = 0;
    start = 0; busy = 0; iaddr = 0;
    cwr = 0; caddr_wr = 0; cdata_wr = 0;
    crd = 0; caddr_rd = 0; csel = 0;
    dbg_sel = 0; dbg_addr = 0;
  endtask

  function automatic logic [12:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 13'($urandom_range(0, 8191));
    return 13'($urandom_range(0, 1023));
  endfunction

  task automatic rnd_access();
    cwr      = ($urandom_range(0, 2) == 0);
    crd      = ($urandom_range(0, 2) == 0);
    csel     = 1'($urandom_range(0, 1));
    caddr_wr = rnd_addr();
    caddr_rd = rnd_addr();
    cdata_wr = 13'($urandom);
    dbg_sel  = 1'($urandom_range(0, 1));
    dbg_addr = 12'($urandom_range(0, 1023));
    iaddr    = 13'($urandom_range(0, 4200));
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1;
    #1;
    cmp("rst_ready", 32'(ready), 32'd0);
    cmp("rst_err", 32'(err), 32'd0);
    cmp("rst_cnt0", 32'(wr_cnt0), 32'd0);

    for (int k = 0; k < 4096; k++) begin
      ld_valid = 1; ld_addr = 12'(k); ld_data = 13'(k);
      tick();
    end
    ld_valid = 0;

    start = 1;
    tick();
    start = 0;
    #1;
    cmp("offer_ready", 32'(ready), 32'd1);
    iaddr = 13'd100;
    #1;
    cmp("idata_100", 32'(idata), 32'd100);
    iaddr = 13'd4096;
    #1;
    cmp("idata_oor", 32'(idata), 32'd0);
    cmp("idata_oor_err", 32'(err), 32'd0);

    for (int i = 0; i < 15; i++) tick();
    cmp("tmo_ready_hold", 32'(ready), 32'd1);
    tick();
    cmp("tmo_ready_fall", 32'(ready), 32'd0);
    cmp("tmo_err1", 32'(err[1]), 32'd1);

    start = 1;
    tick();
    start = 0;
    tick();
    tick();
    busy = 1;
    tick();
    cmp("run_ready_low", 32'(ready), 32'd0);
    cmp("restart_err", 32'(err), 32'd0);

    cwr = 1; csel = 0;
    for (int a = 0; a < 4096; a++) begin
      caddr_wr = 13'(a); cdata_wr = 13'(a) ^ 13'h1555;
      tick();
    end
    csel = 1;
    for (int a = 0; a < 1024; a++) begin
      caddr_wr = 13'(a); cdata_wr = 13'(a);
      tick();
    end
    cwr = 0;
    #1;
    cmp("cnt0_full", 32'(wr_cnt0), 32'd4096);
    cmp("cnt1_full", 32'(wr_cnt1), 32'd1024);
    dbg_sel = 0;
    for (int a = 0; a < 4096; a++) begin
      dbg_addr = 12'(a);
      #1;
      cmp("dbg0", 32'(dbg_data), 32'(13'(a) ^ 13'h1555));
    end
    dbg_sel = 1;
    for (int a = 0; a < 1024; a++) begin
      dbg_addr = 12'(a);
      #1;
      cmp("dbg1", 32'(dbg_data), 32'(a));
    end

    @(posedge clk);
    #1;
    csel = 0; cwr = 1; caddr_wr = 13'd7; cdata_wr = 13'd5;
    tick();
    cdata_wr = 13'd9; crd = 1; caddr_rd = 13'd7;
    #1;
    cmp("rdw_old", 32'(cdata_rd), 32'd5);
    tick();
    cwr = 0;
    #1;
    cmp("rdw_new", 32'(cdata_rd), 32'd9);
    crd = 0;

    csel = 1; caddr_wr = 13'd1024; cwr = 1;
    tick();
    cwr = 0;
    #1;
    cmp("oor_err0", 32'(err[0]), 32'd1);
    cmp("oor_cnt1", 32'(wr_cnt1), 32'd1024);
    cmp("oor_cnt0", 32'(wr_cnt0), 32'd4098);

    for (int i = 0; i < 300; i++) begin
      rnd_access();
      tick();
    end
    cwr = 0; crd = 0;

    busy = 0;
    tick();
    cmp("done_hi", 32'(done), 32'd1);
    tick();
    cmp("done_lo", 32'(done), 32'd0);

    start = 1;
    tick();
    start = 0; busy = 1;
    tick();
    csel = 0; cwr = 1; caddr_wr = 13'd3; cdata_wr = 13'd0;
    tick();
    cwr = 0;
    reset = 0;
    tick();
    reset = 1; busy = 0; iaddr = 13'd100;
    #1;
    cmp("mid_rst_ready", 32'(ready), 32'd0);
    cmp("mid_rst_cnt0", 32'(wr_cnt0), 32'd0);
    cmp("mid_rst_cnt1", 32'(wr_cnt1), 32'd0);
    cmp("mid_rst_err", 32'(err), 32'd0);
    cmp("mid_rst_img", 32'(idata), 32'd100);
    tick();
    cmp("mid_rst_idle", 32'(done | ready), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 299) != 0);
      start    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 11) == 0) busy = ~busy;
      ld_valid = ($urandom_range(0, 3) == 0);
      ld_addr  = 12'($urandom);
      ld_data  = 13'($urandom);
      rnd_access();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/atconv_mem_responder.md
Name: atconv_mem_responder

Overview:
- Memory-side responder for the ATCONV accelerator interface.
- Holds the 64x64 input image and serves it on `iaddr`/`idata`.
- Services accelerator writes and reads of the layer-0 (4096-word) and layer-1 (1024-word) result banks via `cwr`/`crd`/`csel`.
- Drives the `ready`/`busy` start handshake, detects run completion, keeps per-bank write counts and sticky protocol-error flags. Sits between the testbench/host and the accelerator.

Parameters:
- DW, 13, data word width (signed 9.4 fixed point)
- IMG_DEPTH, 4096, image and layer-0 bank depth
- L1_DEPTH, 1024, layer-1 bank depth
- START_TIMEOUT, 16, cycles in OFFER without `busy` before abort

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-low (0 = reset)
- ld_valid  input  1  host image-load strobe
- ld_addr  input  12  image load address
- ld_data  input  13  image load data
- start  input  1  host request to launch a run
- ready  output  1  to accelerator: input image available
- busy  input  1  from accelerator: run in progress
- iaddr  input  13  image read address
- idata  output  13  image word at `iaddr`
- cwr  input  1  result write enable
- caddr_wr  input  13  result write address
- cdata_wr  input  13  result write data
- crd  input  1  result read enable
- caddr_rd  input  13  result read address
- cdata_rd  output  13  result read data
- csel  input  1  bank select: 0 = layer0, 1 = layer1
- dbg_sel  input  1  host inspect bank select
- dbg_addr  input  12  host inspect address
- dbg_data  output  13  host inspect data (combinational)
- done  output  1  one-cycle pulse at run completion
- wr_cnt0  output  13  accepted layer-0 writes this run, saturating at 8191
- wr_cnt1  output  11  accepted layer-1 writes this run, saturating at 2047
- err  output  3  sticky: [0] out-of-range access, [1] start timeout, [2] access while not RUN

Behaviour:
- Reset (reset=0 at posedge):
  - Outputs: `ready`=0, `done`=0, counters=0, `err`=0, state=IDLE.
  - Memory contents are NOT cleared.
  - Reset mid-run aborts immediately; the next cycle is IDLE.
- Reads are asynchronous:
  - `idata` = image[`iaddr`[11:0]] when `iaddr` < 4096, else 0.
  - `cdata_rd` = bank[`csel`][`caddr_rd`] when `crd`=1 and the address is in range, else 0.
- Writes take effect at posedge when `cwr`=1.
  - A read of the same address in the same cycle returns the old data.
  - Simultaneous `cwr` and `crd` are both legal.
- Range rule: layer0 address must be < 4096; layer1 address must be < 1024.
  - Out-of-range write is dropped. Out-of-range read returns 0.
  - Either case sets err[0]; counters do not increment on a dropped write.
- State IDLE:
  - `ld_valid` writes image[`ld_addr`] = `ld_data`.
  - `start`=1 -> OFFER; clears counters, `err`[2:1], and the timeout counter.
- State OFFER:
  - `ready`=1; loads are ignored.
  - `busy`=1 sampled -> RUN; `ready` drops to 0 on the same edge.
  - After START_TIMEOUT cycles without `busy` -> IDLE with err[1] set.
- State RUN:
  - `cwr`/`crd` serviced as above; the counter for `csel`'s bank increments per accepted write.
  - `busy` sampled 0 -> DONE.
- State DONE: `done`=1 for exactly one cycle -> IDLE.
- Any `cwr` or `crd` outside RUN:
  - Writes are blocked; reads still return data.
  - err[2] is set.
- `start` outside IDLE is ignored.
- `ld_valid` outside IDLE is ignored with no error.
- `dbg_data` = bank[`dbg_sel`][`dbg_addr`], readable in any state. Layer1 uses `dbg_addr`[9:0].

Test Plan:
- Load image[k]=k for k=0..4095 via `ld_valid`, then `start`:
  - `ready`=1 the next cycle.
  - `iaddr`=100 -> `idata`=100; `iaddr`=4096 -> `idata`=0 with `err` unchanged.
- Start handshake: pulse `start`, hold `busy`=0 for 16 cycles -> `ready` falls, err[1]=1, state IDLE. Restart and raise `busy` on cycle 3 -> `ready`=0 the next cycle.
- In RUN, write layer0 addr 0..4095 with data=addr^13'h1555 and layer1 addr 0..1023 with data=addr:
  - `wr_cnt0`=4096, `wr_cnt1`=1024.
  - `dbg` readback matches every word.
- Same-cycle `cwr`=1, `crd`=1, `csel`=0, address 7 (old value 5, new value 9) -> `cdata_rd`=5 that cycle, 9 the next cycle.
- `csel`=1, `caddr_wr`=1024, `cwr`=1 -> write dropped, err[0]=1, `wr_cnt1` unchanged.
- Drop `busy` -> `done` high for exactly one cycle. Assert reset mid-RUN -> `ready`=0, counters=0, `err`=0, image contents retained.
